// File: rtl/carregador_instrucoes_pkg.sv
// rtl/carregador_instrucoes_pkg.sv - shared types and constants for the program loader
package pacote_carregador;

    localparam int ADDR_W_PADRAO     = 6;
    localparam int BYTES_POR_PALAVRA = 4;

    typedef enum logic [1:0] {
        OCIOSO,
        RECEBE,
        ESCREVE,
        LIBERA
    } estado_t;

endpackage

// File: rtl/carregador_instrucoes_if.sv
// rtl/carregador_instrucoes_if.sv - byte stream handshake between source and loader
interface carregador_instrucoes_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );

endinterface

// File: rtl/carregador_instrucoes_montador_palavra.sv
// rtl/carregador_instrucoes_montador_palavra.sv - little-endian byte-to-word assembler
module montador_palavra
    import pacote_carregador::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        aceita,
    input  logic        limpa,
    input  logic [7:0]  byte_in,
    output logic [31:0] palavra,
    output logic        completa
);

    localparam int CW = $clog2(BYTES_POR_PALAVRA);

    logic [CW-1:0] contador;

    // Store each accepted byte in its lane; the counter wraps to 0 after the last lane
    always_ff @(posedge clk) begin
        if (reset) begin
            contador <= '0;
            palavra  <= '0;
        end else if (limpa) begin
            contador <= '0;
        end else if (aceita) begin
            palavra[8*contador +: 8] <= byte_in;
            contador                 <= contador + 1'b1;
        end
    end

    // High while the final byte of a word is being taken, so the FSM can move on at this edge
    assign completa = aceita && (contador == CW'(BYTES_POR_PALAVRA - 1));

endmodule

// File: rtl/carregador_instrucoes.sv
// rtl/carregador_instrucoes.sv - loads a byte stream into instruction memory and releases the core
module carregador_instrucoes
    import pacote_carregador::*;
#(
    parameter int ADDR_W = ADDR_W_PADRAO
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W:0]         word_count,
    carregador_instrucoes_if.slave  fonte,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [31:0]             mem_wdata,
    output logic                    cpu_reset,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_W:0] MAX_PALAVRAS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] RESTANTE_UM  = {{ADDR_W{1'b0}}, 1'b1};

    estado_t         estado;
    estado_t         prox;
    logic [ADDR_W:0] restantes;
    logic            aceita;
    logic            limpa;
    logic            completa;
    logic [31:0]     palavra;

    // byte_ready is only high in RECEBE, so this is the handshake as seen at the edge
    assign aceita = (estado == RECEBE) && fonte.byte_valid && fonte.byte_ready;
    assign limpa  = (estado == OCIOSO) && start;

    montador_palavra u_montador (
        .clk      (clk),
        .reset    (reset),
        .aceita   (aceita),
        .limpa    (limpa),
        .byte_in  (fonte.byte_data),
        .palavra  (palavra),
        .completa (completa)
    );

    // The assembly register is already a flop and holds the full word during ESCREVE
    assign mem_wdata = palavra;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    // Next-state logic
    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (start) prox = (word_count == '0) ? LIBERA : RECEBE;
            RECEBE:  if (completa) prox = ESCREVE;
            ESCREVE: prox = (restantes == RESTANTE_UM) ? LIBERA : RECEBE;
            LIBERA:  prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    // Word counter and write address; the address holds on the final word so it cannot wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            restantes <= '0;
            mem_addr  <= '0;
        end else if (limpa) begin
            restantes <= (word_count > MAX_PALAVRAS) ? MAX_PALAVRAS : word_count;
            mem_addr  <= '0;
        end else if (estado == ESCREVE) begin
            restantes <= restantes - 1'b1;
            if (restantes != RESTANTE_UM) begin
                mem_addr <= mem_addr + 1'b1;
            end
        end
    end

    // Status outputs registered from the next state, keeping byte_valid off the byte_ready path
    always_ff @(posedge clk) begin
        if (reset) begin
            fonte.byte_ready <= 1'b0;
            mem_we           <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cpu_reset        <= 1'b1;
        end else begin
            fonte.byte_ready <= (prox == RECEBE);
            mem_we           <= (prox == ESCREVE);
            busy             <= (prox == RECEBE) || (prox == ESCREVE);
            done             <= (prox == LIBERA);
            if ((prox == RECEBE) || (prox == ESCREVE)) begin
                cpu_reset <= 1'b1;
            end else if (prox == LIBERA) begin
                cpu_reset <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb/tb_carregador_instrucoes.sv - self-checking bench for the program loader
module tb_carregador_instrucoes;

    localparam int AW = 6;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } escrita_t;

    typedef struct {
        int n;
        int pct;
        int pulso;
        int esperadas;
    } vetor_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    escrita_t obs[$];
    vetor_t   tabela[8];

    carregador_instrucoes_if bi ();

    carregador_instrucoes #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .fonte      (bi),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nome, atual, esperado);
        end
    endtask

    task automatic check_reset_vals(input string nome);
        check({nome, "_byte_ready"}, {31'd0, bi.byte_ready}, 32'd0);
        check({nome, "_mem_we"},     {31'd0, mem_we},        32'd0);
        check({nome, "_mem_addr"},   {26'd0, mem_addr},      32'd0);
        check({nome, "_mem_wdata"},  mem_wdata,              32'd0);
        check({nome, "_busy"},       {31'd0, busy},          32'd0);
        check({nome, "_done"},       {31'd0, done},          32'd0);
        check({nome, "_cpu_reset"},  {31'd0, cpu_reset},     32'd1);
    endtask

    task automatic aplica_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b0;
        bi.byte_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_vals("reset");
        reset = 1'b0;
    endtask

    // Runs one load and checks it against the reference: the k-th written word is bytes 4k..4k+3
    // of the stream, little-endian, at address k, and exactly 'esperadas' words get written.
    task automatic carregar(input string nome, input int n, input byte_q_t fluxo,
                            input int pct, input int pulso, input int esperadas);
        int idx = 0;
        int ciclo = 0;
        int ciclo_we = -1;
        int ciclo_done = -1;
        int ready_em_we = 0;
        bit fim = 1'b0;
        logic [31:0] esperado;

        obs.delete();
        @(posedge clk); #1;
        start = 1'b1;
        word_count = n[AW:0];
        bi.byte_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check({nome, "_ready_apos_start"}, {31'd0, bi.byte_ready}, {31'd0, esperadas != 0});
        check({nome, "_cpu_reset_apos_start"}, {31'd0, cpu_reset}, {31'd0, esperadas != 0});
        check({nome, "_done_apos_start"}, {31'd0, done}, {31'd0, esperadas == 0});

        while (!fim && ciclo < 3000) begin
            if (idx < fluxo.size() && $urandom_range(99) < pct) begin
                bi.byte_valid = 1'b1;
                bi.byte_data  = fluxo[idx];
            end else begin
                bi.byte_valid = ($urandom_range(99) < pct) ? 1'b1 : 1'b0;
                bi.byte_data  = 8'($urandom);
                if (idx < fluxo.size()) bi.byte_valid = 1'b0;
            end
            start = 1'b0;
            if (pulso >= 0 && ciclo >= pulso && (ciclo % 3) == 0) begin
                start = 1'b1;
                word_count = 7'd5;
            end
            @(negedge clk);
            if (bi.byte_valid && bi.byte_ready) begin
                if (idx < fluxo.size()) idx++;
                else idx = idx + 1000;
            end
            if (mem_we) begin
                obs.push_back('{mem_addr, mem_wdata});
                ciclo_we = ciclo;
                if (bi.byte_ready) ready_em_we++;
            end
            if (done) begin
                ciclo_done = ciclo;
                fim = 1'b1;
            end
            ciclo++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        bi.byte_valid = 1'b0;

        check({nome, "_done_visto"}, {31'd0, fim}, 32'd1);
        check({nome, "_bytes_aceitos"}, idx, fluxo.size());
        check({nome, "_num_escritas"}, obs.size(), esperadas);
        check({nome, "_ready_em_we"}, ready_em_we, 0);
        if (esperadas == 0) check({nome, "_done_latencia"}, ciclo_done, 0);
        else                check({nome, "_done_apos_we"}, ciclo_done - ciclo_we, 1);
        for (int k = 0; k < obs.size() && k < esperadas; k++) begin
            esperado = {fluxo[4*k+3], fluxo[4*k+2], fluxo[4*k+1], fluxo[4*k]};
            check($sformatf("%s_addr%0d", nome, k), {26'd0, obs[k].addr}, k);
            check($sformatf("%s_data%0d", nome, k), obs[k].data, esperado);
        end
        check({nome, "_cpu_reset_final"}, {31'd0, cpu_reset}, 32'd0);
        check({nome, "_busy_final"}, {31'd0, busy}, 32'd0);
        check({nome, "_done_pulso"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        byte_q_t fluxo;
        int we_apos_reset;

        reset = 1'b1;
        start = 1'b0;
        word_count = '0;
        bi.byte_valid = 1'b0;
        bi.byte_data = 8'h00;

        tabela[0] = '{n: 2,   pct: 100, pulso: -1, esperadas: 2};
        tabela[1] = '{n: 2,   pct: 40,  pulso: -1, esperadas: 2};
        tabela[2] = '{n: 0,   pct: 100, pulso: -1, esperadas: 0};
        tabela[3] = '{n: 100, pct: 100, pulso: -1, esperadas: 64};
        tabela[4] = '{n: 1,   pct: 60,  pulso: -1, esperadas: 1};
        tabela[5] = '{n: 65,  pct: 80,  pulso: -1, esperadas: 64};
        tabela[6] = '{n: 3,   pct: 70,  pulso: 2,  esperadas: 3};
        tabela[7] = '{n: 127, pct: 100, pulso: -1, esperadas: 64};

        aplica_reset();

        // Known program, back-to-back bytes
        fluxo = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        carregar("programa", 2, fluxo, 100, -1, 2);
        check("programa_tam", obs.size(), 2);
        if (obs.size() >= 2) begin
            check("programa_w0", obs[0].data, 32'h00500013);
            check("programa_w1", obs[1].data, 32'h00100093);
        end

        // Same program, bursty source
        carregar("programa_irregular", 2, fluxo, 35, -1, 2);

        // Table-driven loads with random payloads
        foreach (tabela[i]) begin
            fluxo.delete();
            for (int b = 0; b < 4 * tabela[i].esperadas; b++) fluxo.push_back(8'($urandom));
            carregar($sformatf("vetor%0d", i), tabela[i].n, fluxo, tabela[i].pct,
                     tabela[i].pulso, tabela[i].esperadas);
        end

        // Reset after two bytes of the first word: nothing written, then a clean reload
        @(posedge clk); #1;
        start = 1'b1;
        word_count = 7'd1;
        @(posedge clk); #1;
        start = 1'b0;
        we_apos_reset = 0;
        bi.byte_valid = 1'b1;
        bi.byte_data = 8'hAA;
        @(posedge clk); #1;
        bi.byte_data = 8'hBB;
        @(posedge clk); #1;
        bi.byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("reset_meio");
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_we) we_apos_reset++;
        end
        check("reset_meio_sem_escrita", we_apos_reset, 0);
        fluxo = '{8'h11, 8'h22, 8'h33, 8'h44};
        carregar("recarga", 1, fluxo, 100, -1, 1);
        check("recarga_tam", obs.size(), 1);
        if (obs.size() >= 1) check("recarga_w0", obs[0].data, 32'h44332211);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/carregador_instrucoes.md
# carregador_instrucoes

Program loader that receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory starting at word address 0. It is the write side of the instruction-fetch path: it holds the single-cycle core in reset through `cpu_reset` while loading, then releases it so fetch starts at PC 0 on the freshly loaded program.

## Interface
- `ADDR_W`, 6: instruction-memory word-address width (64 words, PC bits [7:2]).
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a load; sampled only in OCIOSO.
- `word_count`  in  ADDR_W+1  number of words to load; latched on accepted `start`.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_reset`  out  1  holds the core in reset while high.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when the load completes.

## Operation
- States: OCIOSO, RECEBE, ESCREVE, LIBERA.
- OCIOSO: `byte_ready`=0. On `start`=1, latch `word_count` into `restantes`, saturated to 2^ADDR_W if larger. Then go to RECEBE, or to LIBERA when the latched count is 0. Set `cpu_reset`=1, clear the byte counter and `mem_addr`.
- RECEBE: `byte_ready`=1. A byte is accepted when `byte_valid` and `byte_ready` are both high at the clock edge. Byte n (0..3) goes to word bits [8n+7:8n], so the first byte is the LSB. After byte 3 is accepted, go to ESCREVE.
- ESCREVE: exactly one cycle. `mem_we`=1, `byte_ready`=0, `mem_wdata`=assembled word, `mem_addr`=current address. On exit, increment `mem_addr` and decrement `restantes`. Go to LIBERA if `restantes` was 1, else go to RECEBE.
- LIBERA: exactly one cycle. `done`=1 and `cpu_reset`=0 from this cycle onward. Then go to OCIOSO.
- `busy`=1 in RECEBE and ESCREVE.
- `start` is ignored outside OCIOSO.
- `byte_valid` is ignored while `byte_ready`=0; no byte is lost or duplicated.
- `mem_addr` never wraps, because of the saturation rule.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `cpu_reset`=1. The core stays in reset from `reset` until the first load completes.
- `start` in cycle t gives `byte_ready`=1 in cycle t+1.
- A word is written in the cycle after its 4th byte is accepted.
- Maximum throughput: 1 word per 5 cycles.
- `done` is asserted one cycle after the last `mem_we`.
- `reset` mid-load: everything returns to the reset values next cycle. The partial word is discarded and no write is issued.
- A new `start` after a completed load reasserts `cpu_reset`=1 in the next cycle.
- All outputs are registered. No combinational path runs from `byte_valid` to `byte_ready`.

## Structure
- Shared package `pacote_carregador` holds:
  - the state enum (OCIOSO, RECEBE, ESCREVE, LIBERA);
  - `BYTES_POR_PALAVRA`=4;
  - the default `ADDR_W`.
- Sub-module `montador_palavra` holds the 2-bit byte counter and the 32-bit little-endian assembly register. It has inputs `aceita` and `limpa`, and outputs `palavra` and `completa`.
- The top level contains the FSM, the address and remaining-word counters, and the memory-side outputs.
- `mem_we`, `mem_addr` and `mem_wdata` drive the write port of `memoria_instrucao`.

## Test plan
- Reset, then `start` with `word_count`=2 and bytes 13,00,50,00,93,00,10,00 sent back-to-back. Expected writes: addr 0 = 0x00500013, addr 1 = 0x00100093. `done` pulses once, then `cpu_reset`=0.
- `byte_valid` toggled randomly, including while in ESCREVE. Expected: the same two words. `byte_ready` is low during each `mem_we` cycle, and no byte is lost.
- `word_count`=0. Expected: LIBERA one cycle after `start`, `done`=1, and no `mem_we`.
- `word_count`=100. Expected: exactly 64 writes to addresses 0..63, no wrap, then `done`.
- `reset` after 2 bytes of word 1. Expected: all outputs take their reset values and no write occurs. A reload with `word_count`=1 then writes addr 0 correctly from the first new byte.
- `start` pulsed while `busy`. Expected: it is ignored, and the count and address are unchanged.
